// File: rtl/div_ratio_monitor_if.sv
// Bundle between a divided-clock source/consumer and div_ratio_monitor.
// Handshake: meas_valid qualifies period_out/high_out for exactly one clk
// cycle and there is no ready, so a consumer must capture on the pulse.
// locked and timeout are levels; state_dbg mirrors the FSM state.
interface div_ratio_monitor_if #(
  parameter int CW = 8
);
  logic          sig_in;
  logic [CW-1:0] period_out;
  logic [CW-1:0] high_out;
  logic          meas_valid;
  logic          locked;
  logic          timeout;
  logic          state_dbg;

  modport master (
    output sig_in,
    input  period_out,
    input  high_out,
    input  meas_valid,
    input  locked,
    input  timeout,
    input  state_dbg
  );

  modport slave (
    input  sig_in,
    output period_out,
    output high_out,
    output meas_valid,
    output locked,
    output timeout,
    output state_dbg
  );
endinterface

// File: rtl/div_ratio_monitor.sv
// Measures period and high time of an asynchronous divided clock in clk
// cycles and declares lock after LOCK_CNT consecutive in-tolerance periods.
module div_ratio_monitor #(
  parameter int CW         = 8,
  parameter int EXP_PERIOD = 3,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4
) (
  input logic               clk,
  input logic               rst,
  div_ratio_monitor_if.slave bus
);

  typedef enum logic {
    SEARCH  = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW:0]   EXP_W   = (CW+1)'(EXP_PERIOD);
  localparam logic [CW:0]   TOL_W   = (CW+1)'(TOL);
  localparam logic [3:0]    LOCK_W  = 4'(LOCK_CNT);

  logic          s1, s2, s3;
  state_t        state;
  logic [CW-1:0] hi_cnt, lo_cnt;
  logic [CW-1:0] period_q, high_q;
  logic          meas_valid_q, locked_q, timeout_q;
  logic [3:0]    match_cnt;

  logic          rise;
  logic [CW-1:0] sum;
  logic [CW:0]   sum_w, diff;
  logic          match;
  logic [3:0]    match_next;

  assign rise  = s2 & ~s3;
  assign sum   = hi_cnt + lo_cnt;
  // One extra bit so the distance from EXP_PERIOD never wraps.
  assign sum_w = {1'b0, sum};
  assign diff  = (sum_w >= EXP_W) ? (sum_w - EXP_W) : (EXP_W - sum_w);
  assign match = (diff <= TOL_W);
  assign match_next = (match_cnt >= LOCK_W) ? LOCK_W : (match_cnt + 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= SEARCH;
      hi_cnt       <= '0;
      lo_cnt       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      match_cnt    <= '0;
    end else begin
      meas_valid_q <= 1'b0;
      case (state)
        SEARCH: begin
          if (rise) begin
            state  <= MEASURE;
            hi_cnt <= CW'(1);
            lo_cnt <= '0;
          end
        end
        MEASURE: begin
          // A rise takes priority over saturation, so a full-scale period still publishes.
          if (rise) begin
            period_q     <= sum;
            high_q       <= hi_cnt;
            meas_valid_q <= 1'b1;
            timeout_q    <= 1'b0;
            hi_cnt       <= CW'(1);
            lo_cnt       <= '0;
            if (match) begin
              match_cnt <= match_next;
              locked_q  <= (match_next == LOCK_W);
            end else begin
              match_cnt <= '0;
              locked_q  <= 1'b0;
            end
          end else if (sum == CNT_MAX) begin
            timeout_q <= 1'b1;
            locked_q  <= 1'b0;
            match_cnt <= '0;
            hi_cnt    <= '0;
            lo_cnt    <= '0;
            state     <= SEARCH;
          end else if (s2) begin
            hi_cnt <= hi_cnt + 1'b1;
          end else begin
            lo_cnt <= lo_cnt + 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  assign bus.period_out = period_q;
  assign bus.high_out   = high_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = timeout_q;
  assign bus.state_dbg  = (state == MEASURE);

endmodule

// File: tb/tb_div_ratio_monitor.sv
// Directed bench for div_ratio_monitor: a TOL=0 instance carries most tests,
// a TOL=1 instance is enabled only for the period-4 tolerance case.
module tb_div_ratio_monitor;

  localparam int CW = 8;
  localparam int EW = 2*CW + 2;

  logic clk;
  logic rst;
  logic sig;
  logic en_b;
  logic async_mode;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_valid_cyc_a = 0;
  int valid_cnt_a = 0;
  int async_cnt = 0;

  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];

  div_ratio_monitor_if #(.CW(CW)) a_if ();
  div_ratio_monitor_if #(.CW(CW)) b_if ();

  assign a_if.sig_in = sig;
  assign b_if.sig_in = sig & en_b;

  div_ratio_monitor #(.CW(CW), .EXP_PERIOD(3), .TOL(0), .LOCK_CNT(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  div_ratio_monitor #(.CW(CW), .EXP_PERIOD(3), .TOL(1), .LOCK_CNT(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic run_period(input int hi, input int lo);
    sig = 1'b1;
    repeat (hi) tick();
    sig = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic push_a(input int p, input int h, input logic lk, input logic to);
    check("backlog_a", exp_a_q.size(), 0);
    exp_a_q.push_back({to, lk, CW'(h), CW'(p)});
  endtask

  task automatic push_b(input int p, input int h, input logic lk, input logic to);
    check("backlog_b", exp_b_q.size(), 0);
    exp_b_q.push_back({to, lk, CW'(h), CW'(p)});
  endtask

  // scoreboard for dut_a
  initial begin
    logic [EW-1:0] e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && a_if.meas_valid === 1'b1) begin
        valid_cnt_a++;
        last_valid_cyc_a = cyc;
        if (prev_v) check("valid_width_a", a_if.meas_valid, 0);
        if (async_mode) begin
          async_cnt++;
          check("async_period", (a_if.period_out == 3 || a_if.period_out == 4), 1);
          check("async_high", (a_if.high_out >= 1 && a_if.high_out <= a_if.period_out), 1);
        end else if (exp_a_q.size() == 0) begin
          check("unexp_a", a_if.meas_valid, 0);
        end else begin
          e = exp_a_q.pop_front();
          check("period_a", a_if.period_out, e[CW-1:0]);
          check("high_a", a_if.high_out, e[2*CW-1:CW]);
          check("locked_a", a_if.locked, e[2*CW]);
          check("timeout_a", a_if.timeout, e[2*CW+1]);
        end
      end
      prev_v = (rst === 1'b1) && (a_if.meas_valid === 1'b1);
    end
  end

  // scoreboard for dut_b
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && b_if.meas_valid === 1'b1) begin
        if (exp_b_q.size() == 0) begin
          check("unexp_b", b_if.meas_valid, 0);
        end else begin
          e = exp_b_q.pop_front();
          check("period_b", b_if.period_out, e[CW-1:0]);
          check("high_b", b_if.high_out, e[2*CW-1:CW]);
          check("locked_b", b_if.locked, e[2*CW]);
          check("timeout_b", b_if.timeout, e[2*CW+1]);
        end
      end
    end
  end

  initial begin
    int n;
    int vc;
    sig = 1'b0;
    en_b = 1'b0;
    async_mode = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    check("rst_period", a_if.period_out, 0);
    check("rst_high", a_if.high_out, 0);
    check("rst_valid", a_if.meas_valid, 0);
    check("rst_locked", a_if.locked, 0);
    check("rst_timeout", a_if.timeout, 0);
    check("rst_state", a_if.state_dbg, 0);
    rst = 1'b1;

    // period 3 (high 1, low 2): lock on 4th pulse
    run_period(1, 2);
    for (int i = 1; i <= 6; i++) begin
      push_a(3, 1, (i >= 4), 1'b0);
      run_period(1, 2);
    end

    // one period of 5 drops lock, four good periods relock
    push_a(3, 1, 1'b1, 1'b0);
    run_period(1, 4);
    push_a(5, 1, 1'b0, 1'b0);
    run_period(1, 2);
    for (int i = 1; i <= 4; i++) begin
      push_a(3, 1, (i == 4), 1'b0);
      run_period(1, 2);
    end

    // hold low after lock: timeout 255 cycles after the last counted rise
    push_a(3, 1, 1'b1, 1'b0);
    run_period(1, 2);
    n = 0;
    while (a_if.timeout !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("to_seen", a_if.timeout, 1);
    check("to_delay", cyc - last_valid_cyc_a, 255);
    check("to_locked", a_if.locked, 0);
    check("to_keep_period", a_if.period_out, 3);
    check("to_keep_high", a_if.high_out, 1);
    check("to_state", a_if.state_dbg, 0);
    run_period(1, 2);
    check("to_sticky", a_if.timeout, 1);
    for (int i = 1; i <= 4; i++) begin
      push_a(3, 1, (i == 4), 1'b0);
      run_period(1, 2);
    end

    // reset mid-period while locked
    check("pre_rst_locked", a_if.locked, 1);
    sig = 1'b1;
    tick();
    sig = 1'b0;
    tick();
    #1 rst = 1'b0;
    #1;
    check("mid_rst_period", a_if.period_out, 0);
    check("mid_rst_high", a_if.high_out, 0);
    check("mid_rst_valid", a_if.meas_valid, 0);
    check("mid_rst_locked", a_if.locked, 0);
    check("mid_rst_timeout", a_if.timeout, 0);
    check("mid_rst_state", a_if.state_dbg, 0);
    tick();
    tick();
    rst = 1'b1;
    vc = valid_cnt_a;
    run_period(1, 2);
    check("rst_one_rise", valid_cnt_a, vc);
    push_a(3, 1, 1'b0, 1'b0);
    run_period(1, 2);
    repeat (3) tick();
    check("drain_a_rst", exp_a_q.size(), 0);
    check("rst_two_rises", valid_cnt_a, vc + 1);

    // high 2 / low 2: TOL=0 never locks, TOL=1 locks on 4th pulse
    rst = 1'b0;
    tick();
    rst = 1'b1;
    en_b = 1'b1;
    run_period(2, 2);
    for (int i = 1; i <= 6; i++) begin
      push_a(4, 2, 1'b0, 1'b0);
      push_b(4, 2, (i >= 4), 1'b0);
      run_period(2, 2);
    end
    repeat (3) tick();
    check("drain_a_p4", exp_a_q.size(), 0);
    check("drain_b_p4", exp_b_q.size(), 0);
    en_b = 1'b0;

    // asynchronous 35 ns input against 10 ns clk
    rst = 1'b0;
    tick();
    rst = 1'b1;
    async_mode = 1'b1;
    async_cnt = 0;
    #3;
    repeat (20) begin
      sig = 1'b1;
      #15;
      sig = 1'b0;
      #20;
    end
    repeat (5) tick();
    async_mode = 1'b0;
    check("async_cnt", async_cnt, 19);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_ratio_monitor.md
# div_ratio_monitor

Measures an incoming divided clock (e.g. a divide-by-2/3/4/5 output of the dual-clock divider) against the local reference clock. It reports period and high time in reference-clock cycles and raises `locked` once the measured period has matched the expected division ratio for a programmable number of consecutive periods. It is the checking end of the divider path, used for self-test and for gating downstream logic until the divided clock is stable.

## Interface
- `CW`, 8: counter/result width; longest measurable period is 2^CW-1 cycles.
- `EXP_PERIOD`, 3: expected period of `sig_in` in `clk` cycles.
- `TOL`, 0: allowed absolute deviation from `EXP_PERIOD`.
- `LOCK_CNT`, 4: consecutive matching periods required for lock (1..15).
- `clk`  in  1  reference clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `sig_in`  in  1  divided clock under test; asynchronous to `clk`.
- `period_out`  out  CW  last measured period, in `clk` cycles.
- `high_out`  out  CW  high time within that period, in `clk` cycles.
- `meas_valid`  out  1  one-cycle pulse when `period_out`/`high_out` update.
- `locked`  out  1  period has matched LOCK_CNT times in a row.
- `timeout`  out  1  no rising edge within 2^CW-1 cycles; sticky until the next measurement.

## Operation
- Input path: 2-flop synchronizer (`s1`, `s2`), then a delay flop `s3`. Rise detected when `s2 & ~s3`. All counting uses `s2`.
- States:
  - SEARCH (reset state): counters idle. Rise -> MEASURE, `hi_cnt`<=1, `lo_cnt`<=0.
  - MEASURE, no rise: `hi_cnt`+1 if `s2`=1, else `lo_cnt`+1.
  - MEASURE, rise: publish `period_out`<=`hi_cnt`+`lo_cnt`, `high_out`<=`hi_cnt`, `meas_valid`<=1, `timeout`<=0. Restart with `hi_cnt`<=1, `lo_cnt`<=0. Stay in MEASURE.
- Timeout: in MEASURE with no rise and `hi_cnt`+`lo_cnt` == 2^CW-1:
  - `timeout`<=1, `locked`<=0, `match_cnt`<=0.
  - Counters cleared; state -> SEARCH.
  - `period_out`/`high_out` keep their last values.
- Simultaneous rise and saturation: the rise wins. Publish `period_out`=2^CW-1; no timeout.
- Match check on each publish: match = |P - EXP_PERIOD| <= TOL, where P is the value being published; compare at CW+1 bits, no wrap.
  - Match: `match_cnt` increments, saturating at LOCK_CNT. `locked`<=1 when the new `match_cnt` == LOCK_CNT.
  - Mismatch: `match_cnt`<=0, `locked`<=0.
  - `locked` updates on the same edge as `meas_valid`.
- Arithmetic: `hi_cnt`+`lo_cnt` never exceeds 2^CW-1 by construction, so the period sum never overflows. `match_cnt` is 4 bits.
- `rst`=0 at any time (mid-measurement included): every flop clears immediately and the state returns to SEARCH. The first measurement after reset needs two detected rises.

## Timing
- Reset values: `period_out`=0, `high_out`=0, `meas_valid`=0, `locked`=0, `timeout`=0. Synchronizer flops, counters and `match_cnt` = 0.
- Detection latency: `sig_in` first sampled high at edge k -> rise visible combinationally after edge k+1 -> `meas_valid` high after edge k+2, for exactly one cycle.
- For a `sig_in` of steady period P cycles (P >= 2), `meas_valid` pulses every P cycles.
- P=1 is not measurable; P >= 2 is required.
- `locked` asserts no earlier than LOCK_CNT+1 rises after reset. It deasserts on the first bad publish or timeout.

## Test plan
- Reset, then `sig_in` high 1 / low 2 cycles, synchronous to `clk` -> every 3 cycles `meas_valid`=1, `period_out`=3, `high_out`=1. `locked`=1 on the 4th valid pulse and stays 1.
- `sig_in` high 2 / low 2 with EXP_PERIOD=3, TOL=0 -> `period_out`=4, `locked` never asserts. Repeat with TOL=1 -> lock after 4 pulses.
- Locked at period 3, then one period of 5 -> that pulse shows `period_out`=5 and `locked`=0. Relock after 4 more good periods.
- `sig_in` held low 300 cycles after lock, CW=8 -> `timeout`=1 and `locked`=0, 255 cycles after the last counted rise. Resume period 3 -> first `meas_valid` clears `timeout`; `period_out`=3 on the second rise.
- Pulse `rst` low mid-period while locked -> all outputs 0 immediately. Next `meas_valid` only after two rises.
- `sig_in` asynchronous period 35 ns against a 10 ns `clk` -> `period_out` is 3 or 4 on every valid pulse, and `high_out` <= `period_out`.
